jk_ff_driver: RTL and testbench

Sequencing driver for a JK flip-flop. It accepts target-state requests over a valid/ready handshake and computes the JK excitation from the flop's current output. It drives that excitation for exactly one clock, then holds the flop (J=K=0) for a programmable number of cycles, checking Q and Q_N against the target on every hold cycle. It sits on the stimulus side of the `jk_ff` flop, as the reusable replacement for hand-written J/K stimulus sequences, and reports transfer and error counts.

---
 rtl/jk_ff_driver.sv | 145 ++++++++++++++
 tb/tb_jk_ff_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_ff_driver.sv
// Sequences target-state requests onto a JK flop: one excite cycle, then tgt_len+1 checked hold cycles.
// Latency: j/k registered one edge after accept; occupancy tgt_len+3 cycles from accept to next accept.
// Backpressure: tgt_ready only in IDLE; requester holds tgt_valid until accepted. Optional check: JK_FF_DRIVER_CHECK_EN.
module jk_ff_driver #(
    parameter int CNT_W   = 8,
    parameter bit DC_FILL = 1'b0,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             tgt_bit,
    input  logic [LEN_W-1:0] tgt_len,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    input  logic             q_n_in,
    input  logic             cnt_clr,
    output logic             busy,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXCITE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             tgt_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] hcnt;
    logic             accept;
    logic             hold_last;

    // Excitation {j,k} that moves the flop from q to t in a single edge.
    function automatic logic [1:0] excite(input logic q, input logic t);
        logic [1:0] jk;
        if (!q) begin
            jk = {t, DC_FILL};
        end else begin
            jk = {DC_FILL, ~t};
        end
        return jk;
    endfunction

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = tgt_valid && tgt_ready;
    assign hold_last = (state == HOLD) && (hcnt == len_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt_r <= 1'b0;
            len_r <= '0;
            hcnt  <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    j <= 1'b0;
                    k <= 1'b0;
                    if (accept) begin
                        tgt_r  <= tgt_bit;
                        len_r  <= tgt_len;
                        {j, k} <= excite(q_in, tgt_bit);
                        state  <= EXCITE;
                    end
                end
                EXCITE: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    hcnt  <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    j <= 1'b0;
                    k <= 1'b0;
                    if (hcnt == len_r) begin
                        state <= IDLE;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Clear takes priority over a completion on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (cnt_clr) begin
            xfer_cnt <= '0;
        end else if (hold_last && (xfer_cnt != CNT_MAX)) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

`ifdef JK_FF_DRIVER_CHECK_EN
    logic chk_fail;

    // A hold sample fails on a wrong Q or on Q_N not being the complement of Q.
    assign chk_fail = (state == HOLD) && ((q_in != tgt_r) || (q_n_in != ~q_in));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= chk_fail;
            if (cnt_clr) begin
                err_cnt <= '0;
            end else if (chk_fail && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_chk;

    assign err_pulse  = 1'b0;
    assign err_cnt    = '0;
    assign unused_chk = q_n_in ^ tgt_r;
`endif

    a_jk_only_in_excite : assert property (@(posedge clk) disable iff (!rst_n)
        (j || k) |-> (state == EXCITE));

    a_hcnt_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        (state == HOLD) |-> (hcnt <= len_r));

endmodule

// File: tb/tb_jk_ff_driver.sv
// Bench: two drivers (8-bit counters/DC_FILL=0 and 2-bit counters/DC_FILL=1) each driving a modelled JK flop.
module tb_jk_ff_driver;

`ifdef JK_FF_DRIVER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tgt_valid, tgt_bit, cnt_clr;
    logic [3:0] tgt_len;
    logic [1:0] rdy, j_o, k_o, bsy, errp, q_ff, q_in, qn_in;
    logic [7:0] errc0, xf0;
    logic [1:0] errc1, xf1;
    logic       q_load, q_load_val, q_force, q_force_val, qn_bad;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jk_ff_driver #(.CNT_W(8), .DC_FILL(1'b0), .LEN_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy[0]),
        .tgt_bit(tgt_bit), .tgt_len(tgt_len), .j(j_o[0]), .k(k_o[0]),
        .q_in(q_in[0]), .q_n_in(qn_in[0]), .cnt_clr(cnt_clr), .busy(bsy[0]),
        .err_pulse(errp[0]), .err_cnt(errc0), .xfer_cnt(xf0)
    );

    jk_ff_driver #(.CNT_W(2), .DC_FILL(1'b1), .LEN_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy[1]),
        .tgt_bit(tgt_bit), .tgt_len(tgt_len), .j(j_o[1]), .k(k_o[1]),
        .q_in(q_in[1]), .q_n_in(qn_in[1]), .cnt_clr(cnt_clr), .busy(bsy[1]),
        .err_pulse(errp[1]), .err_cnt(errc1), .xfer_cnt(xf1)
    );

    // The driven JK flops, with bench-side load, stuck-at and Q_N corruption controls.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (q_load) q_ff[d] <= q_load_val;
            else begin
                case ({j_o[d], k_o[d]})
                    2'b01:   q_ff[d] <= 1'b0;
                    2'b10:   q_ff[d] <= 1'b1;
                    2'b11:   q_ff[d] <= ~q_ff[d];
                    default: q_ff[d] <= q_ff[d];
                endcase
            end
        end
    end

    assign q_in  = q_force ? {2{q_force_val}} : q_ff;
    assign qn_in = qn_bad ? q_in : ~q_in;

    // Transaction model: an accept at edge N drives the excitation after N,
    // checks at edges N+2 .. N+2+len, and frees the requester after the last one.
    int       cyc, acc, len_m, xfer_raw;
    int       err_raw [2];
    bit       active, tgt_m;
    bit [1:0] m_j, m_k, m_ep;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; acc <= 0; len_m <= 0; xfer_raw <= 0;
            active <= 1'b0; tgt_m <= 1'b0;
            m_j <= '0; m_k <= '0; m_ep <= '0;
            for (int d = 0; d < 2; d++) err_raw[d] <= 0;
        end else begin
            cyc  <= cyc + 1;
            m_j  <= '0;
            m_k  <= '0;
            m_ep <= '0;
            if (!active) begin
                if (tgt_valid) begin
                    active <= 1'b1;
                    acc    <= cyc;
                    tgt_m  <= tgt_bit;
                    len_m  <= int'(tgt_len);
                    for (int d = 0; d < 2; d++) begin
                        if (!q_in[d]) begin
                            m_j[d] <= tgt_bit;
                            m_k[d] <= (d == 1);
                        end else begin
                            m_j[d] <= (d == 1);
                            m_k[d] <= ~tgt_bit;
                        end
                    end
                end
            end else if (cyc >= acc + 2) begin
                for (int d = 0; d < 2; d++) begin
                    m_ep[d]    <= CHK && ((q_in[d] != tgt_m) || (qn_in[d] == q_in[d]));
                    err_raw[d] <= err_raw[d] + int'(CHK && ((q_in[d] != tgt_m) || (qn_in[d] == q_in[d])));
                end
                if (cyc == acc + 2 + len_m) begin
                    active   <= 1'b0;
                    xfer_raw <= xfer_raw + 1;
                end
            end
            if (cnt_clr) begin
                xfer_raw <= 0;
                for (int d = 0; d < 2; d++) err_raw[d] <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp_model();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d.j", d), int'(j_o[d]), int'(m_j[d]));
            chk($sformatf("dut%0d.k", d), int'(k_o[d]), int'(m_k[d]));
            chk($sformatf("dut%0d.tgt_ready", d), int'(rdy[d]), int'(!active));
            chk($sformatf("dut%0d.busy", d), int'(bsy[d]), int'(active));
            chk($sformatf("dut%0d.err_pulse", d), int'(errp[d]), int'(m_ep[d]));
        end
        chk("dut0.err_cnt", int'(errc0), sat(err_raw[0], 255));
        chk("dut1.err_cnt", int'(errc1), sat(err_raw[1], 3));
        chk("dut0.xfer_cnt", int'(xf0), sat(xfer_raw, 255));
        chk("dut1.xfer_cnt", int'(xf1), sat(xfer_raw, 3));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    // Returns at the negedge just after the accept edge.
    task automatic do_req(input logic b, input logic [3:0] l);
        int g = 0;
        tgt_valid = 1'b1;
        tgt_bit   = b;
        tgt_len   = l;
        while (!rdy[0] && g < 50) begin
            tick();
            g++;
        end
        if (!rdy[0]) begin
            tests++;
            fails++;
            $display("FAIL req_accept: tgt_ready=%0d after %0d cycles, required 1", rdy[0], g);
        end
        tick();
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!rdy[0] && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        rst_n = 1'b0;
        tgt_valid = 1'b0; tgt_bit = 1'b0; tgt_len = 4'd0; cnt_clr = 1'b0;
        q_load = 1'b1; q_load_val = 1'b0; q_force = 1'b0; q_force_val = 1'b0; qn_bad = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_j", int'(j_o[0]), 0);
        chk("rst_k", int'(k_o[0]), 0);
        chk("rst_ready", int'(rdy[0]), 1);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_xfer", int'(xf0), 0);
        cmp_model();
        q_load = 1'b0;
        rst_n  = 1'b1;
        tick();

        // Set from reset: Q=0 -> 1, hold 10 cycles.
        do_req(1'b1, 4'd9);
        chk("set_j0", int'(j_o[0]), 1);
        chk("set_k0", int'(k_o[0]), 0);
        chk("set_k1", int'(k_o[1]), 1);
        tick();
        chk("set_j_after", int'(j_o[0]), 0);
        chk("set_q", int'(q_in[0]), 1);
        wait_idle(n);
        chk("set_ready_delay", n, 10);
        chk("set_xfer", int'(xf0), 1);
        chk("set_err", int'(errc0), 0);

        // Reset excitation: Q=1 -> 0, len 0.
        do_req(1'b0, 4'd0);
        chk("rstx_j0", int'(j_o[0]), 0);
        chk("rstx_k0", int'(k_o[0]), 1);
        chk("rstx_j1", int'(j_o[1]), 1);
        chk("rstx_k1", int'(k_o[1]), 1);
        wait_idle(n);
        chk("rstx_ready_delay", n, 2);
        chk("rstx_q0", int'(q_in[0]), 0);
        chk("rstx_q1", int'(q_in[1]), 0);
        chk("rstx_xfer", int'(xf0), 2);

        // Keep current state at 0 under both fill values.
        do_req(1'b0, 4'd3);
        chk("keep_j0", int'(j_o[0]), 0);
        chk("keep_k0", int'(k_o[0]), 0);
        chk("keep_j1", int'(j_o[1]), 0);
        chk("keep_k1", int'(k_o[1]), 1);
        wait_idle(n);
        chk("keep_ready_delay", n, 5);
        chk("keep_q0", int'(q_in[0]), 0);
        chk("keep_q1", int'(q_in[1]), 0);
        chk("keep_err", int'(errc0), 0);
        chk("keep_xfer", int'(xf0), 3);

        // Error injection: Q stuck at 0 while targeting 1.
        q_force = 1'b1; q_force_val = 1'b0;
        do_req(1'b1, 4'd3);
        n = 0; pulses = 0;
        while (!rdy[0] && n < 50) begin
            tick();
            n++;
            pulses += int'(errp[0]);
        end
        chk("stuck_pulses", pulses, CHK ? 4 : 0);
        chk("stuck_err0", int'(errc0), CHK ? 4 : 0);
        chk("stuck_err1_sat", int'(errc1), CHK ? 3 : 0);
        chk("stuck_xfer0", int'(xf0), 4);
        chk("stuck_xfer1_sat", int'(xf1), 3);
        q_force = 1'b0;

        // Correct Q but Q_N equal to Q.
        qn_bad = 1'b1;
        do_req(1'b1, 4'd3);
        n = 0; pulses = 0;
        while (!rdy[0] && n < 50) begin
            tick();
            n++;
            pulses += int'(errp[0]);
        end
        chk("qn_q0", int'(q_in[0]), 1);
        chk("qn_pulses", pulses, CHK ? 4 : 0);
        chk("qn_err0", int'(errc0), CHK ? 8 : 0);
        qn_bad = 1'b0;

        // Reset during HOLD.
        do_req(1'b1, 4'd9);
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_j", int'(j_o[0]), 0);
        chk("mid_rst_k", int'(k_o[0]), 0);
        chk("mid_rst_busy", int'(bsy[0]), 0);
        chk("mid_rst_xfer", int'(xf0), 0);
        chk("mid_rst_err", int'(errc0), 0);
        cmp_model();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", int'(rdy[0]), 1);
        do_req(1'b0, 4'd2);
        wait_idle(n);
        chk("post_rst_ready_delay", n, 4);
        chk("post_rst_q", int'(q_in[0]), 0);
        chk("post_rst_xfer", int'(xf0), 1);

        // Saturation of the 2-bit counter, then clear on a completing edge.
        for (int i = 0; i < 4; i++) begin
            do_req(i[0], 4'd0);
            wait_idle(n);
        end
        chk("sat_xfer0", int'(xf0), 5);
        chk("sat_xfer1", int'(xf1), 3);
        do_req(1'b1, 4'd0);
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_ready", int'(rdy[0]), 1);
        chk("clr_xfer0", int'(xf0), 0);
        chk("clr_xfer1", int'(xf1), 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
